// File: rtl/datasg_pkg.sv
// Shared types and default sizing for the packet write-data segmenter.
package datasg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 12;
  localparam int DES_W_DEF  = 4;
  localparam int PRI_W_DEF  = 3;
  localparam int DEPTH_DEF  = 16;
  localparam int LEN_W_DEF  = 8;

endpackage

// File: rtl/datasg_fifo.sv
// Synchronous FIFO with show-ahead read data; full/empty/count come from a registered occupancy count.
module datasg_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic do_push;
  logic do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/datasg_pkt.sv
// Buffers ingress packet beats, arbitrates for the SRAM write port and streams them to wrapping addresses,
// reporting start address and length of each finished packet.
module datasg_pkt
  import datasg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DES_W  = DES_W_DEF,
  parameter int PRI_W  = PRI_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [PRI_W-1:0]  in_priority,
  input  logic [DES_W-1:0]  in_des,
  output logic              request,
  input  logic              grant,
  input  logic              busy,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [PRI_W-1:0]  wr_priority,
  output logic [DES_W-1:0]  wr_des,
  output logic              pkt_done,
  output logic [ADDR_W-1:0] pkt_addr,
  output logic [LEN_W-1:0]  pkt_len
);

  localparam int EW = 2 + PRI_W + DES_W + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;

  state_t state;
  state_t state_nxt;

  logic [EW-1:0]     head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              push;
  logic              pop;
  logic [CW-1:0]     eop_cnt;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  len_cnt;

  logic              h_sop;
  logic              h_eop;
  logic [PRI_W-1:0]  h_pri;
  logic [DES_W-1:0]  h_des;
  logic [DATA_W-1:0] h_data;

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign pop      = (state == XFER) && !busy && !fifo_empty;
  assign request  = (state != IDLE);

  assign h_sop  = head[EW-1];
  assign h_eop  = head[EW-2];
  assign h_pri  = head[DES_W+DATA_W +: PRI_W];
  assign h_des  = head[DATA_W +: DES_W];
  assign h_data = head[DATA_W-1:0];

  datasg_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({in_sop, in_eop, in_priority, in_des, in_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      eop_cnt <= '0;
    end else if (push && in_eop && !(pop && h_eop)) begin
      eop_cnt <= eop_cnt + CW'(1);
    end else if (pop && h_eop && !(push && in_eop)) begin
      eop_cnt <= eop_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A full FIFO with no eop inside is an oversized packet: start writing it anyway.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (eop_cnt != '0 || fifo_count == CW'(DEPTH)) state_nxt = REQ;
      REQ:     if (grant) state_nxt = XFER;
      XFER:    if (pop && h_eop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_priority <= '0;
      wr_des      <= '0;
      pkt_done    <= 1'b0;
      pkt_addr    <= '0;
      pkt_len     <= '0;
      wptr        <= '0;
      start_addr  <= '0;
      len_cnt     <= '0;
    end else begin
      wr_valid <= pop;
      pkt_done <= pop && h_eop;
      if (pop) begin
        wr_addr <= wptr;
        wr_data <= h_data;
        wptr    <= wptr + ADDR_W'(1);
        if (h_sop) begin
          wr_priority <= h_pri;
          wr_des      <= h_des;
          start_addr  <= wptr;
          len_cnt     <= LEN_W'(1);
        end else begin
          len_cnt <= len_cnt + LEN_W'(1);
        end
        if (h_eop) begin
          pkt_addr <= h_sop ? wptr : start_addr;
          pkt_len  <= h_sop ? LEN_W'(1) : len_cnt + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_datasg_pkt.sv
// Randomized and directed bench for datasg_pkt against a queue-based model of the written word stream.
module tb_datasg_pkt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [2:0]  in_priority = '0;
  logic [3:0]  in_des = '0;
  logic        request;
  logic        grant = 1'b0;
  logic        busy = 1'b0;
  logic        wr_valid;
  logic [11:0] wr_addr;
  logic [63:0] wr_data;
  logic [2:0]  wr_priority;
  logic [3:0]  wr_des;
  logic        pkt_done;
  logic [11:0] pkt_addr;
  logic [7:0]  pkt_len;

  datasg_pkt dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_priority(in_priority), .in_des(in_des),
    .request(request), .grant(grant), .busy(busy), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_priority(wr_priority), .wr_des(wr_des), .pkt_done(pkt_done),
    .pkt_addr(pkt_addr), .pkt_len(pkt_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sop;
    logic        eop;
    logic [2:0]  pri;
    logic [3:0]  des;
    logic [63:0] data;
  } beat_t;

  typedef struct {
    int unsigned addr;
    int unsigned len;
  } done_t;

  beat_t exp_q[$];
  done_t log_q[$];

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  int unsigned mwptr = 0;
  int unsigned mstart = 0;
  int unsigned mlen = 0;
  logic [2:0]  mpri = '0;
  logic [3:0]  mdes = '0;
  bit          have_last = 0;
  logic [11:0] last_addr = '0;
  logic [63:0] last_data = '0;
  bit          prev_busy = 0;
  bit          prev_req = 0;
  int          req_rises = 0;
  int          wv_cnt = 0;
  int unsigned wv_first = 0;
  int unsigned wv_last = 0;

  bit gmode = 0;
  bit bmode = 0;
  bit gconst = 0;
  bit bconst = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Arbiter / SRAM emulation, updated just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      grant = gmode ? ($urandom_range(0, 2) != 0) : gconst;
      busy  = bmode ? ($urandom_range(0, 3) == 0) : bconst;
    end
  end

  // Every written word must be the next accepted beat, at the next sequential address.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_busy = 0;
        prev_req  = 0;
      end else begin
        if (prev_busy) chk("busy_gap", {63'd0, wr_valid}, 64'd0);
        if (wr_valid) begin
          if (wv_cnt == 0) wv_first = cyc;
          wv_last = cyc;
          wv_cnt++;
          if (exp_q.size() == 0) begin
            chk("spurious_wr", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            if (e.sop) begin
              mstart = mwptr;
              mlen   = 1;
              mpri   = e.pri;
              mdes   = e.des;
            end else begin
              mlen = (mlen + 1) % 256;
            end
            chk("wr_data", wr_data, e.data);
            chk("wr_addr", {52'd0, wr_addr}, 64'(mwptr));
            chk("wr_priority", {61'd0, wr_priority}, {61'd0, mpri});
            chk("wr_des", {60'd0, wr_des}, {60'd0, mdes});
            chk("pkt_done", {63'd0, pkt_done}, {63'd0, e.eop});
            if (e.eop) begin
              chk("pkt_addr", {52'd0, pkt_addr}, 64'(mstart));
              chk("pkt_len", {56'd0, pkt_len}, 64'(mlen));
              log_q.push_back('{addr: pkt_addr, len: pkt_len});
            end
            mwptr     = (mwptr + 1) % 4096;
            have_last = 1;
            last_addr = wr_addr;
            last_data = wr_data;
          end
        end else begin
          chk("done_no_wr", {63'd0, pkt_done}, 64'd0);
          if (have_last) begin
            chk("hold_addr", {52'd0, wr_addr}, {52'd0, last_addr});
            chk("hold_data", wr_data, last_data);
          end
        end
        if (request && !prev_req) req_rises++;
        prev_busy = busy;
        prev_req  = request;
      end
    end
  end

  // Called and returns at posedge+1.
  task automatic send_beat(input logic sop, input logic eop, input logic [2:0] pri,
                           input logic [3:0] des, input logic [63:0] data);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_sop = sop;
    in_eop = eop;
    in_priority = pri;
    in_des = des;
    in_data = data;
    acc = 0;
    n = 0;
    while (!acc && n < 3000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    if (acc) exp_q.push_back('{sop: sop, eop: eop, pri: pri, des: des, data: data});
    else chk("in_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_pkt(input int len, input int gapmax);
    logic [2:0] pri;
    logic [3:0] des;
    pri = 3'($urandom);
    des = 4'($urandom);
    for (int i = 0; i < len; i++) begin
      send_beat(i == 0, i == len - 1, (i == 0) ? pri : 3'($urandom),
                (i == 0) ? des : 4'($urandom), {$urandom, $urandom});
      repeat ($urandom_range(0, gapmax)) @(posedge clk);
      #0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    log_q.delete();
    mwptr = 0;
    mlen = 0;
    have_last = 0;
    req_rises = 0;
    wv_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_valid", {63'd0, wr_valid}, 64'd0);
    chk("rst_request", {63'd0, request}, 64'd0);
    chk("rst_pkt_done", {63'd0, pkt_done}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_wr_addr", {52'd0, wr_addr}, 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_pri_des", {57'd0, wr_priority, wr_des}, 64'd0);
    chk("rst_pkt_addr_len", {44'd0, pkt_addr, pkt_len}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int npk;
    @(posedge clk);
    #1;
    do_reset();

    // Single 1-beat packet: latency and literal outputs.
    gconst = 1;
    send_beat(1'b1, 1'b1, 3'd5, 4'd3, 64'hA5);
    @(negedge clk);
    chk("t1_wv_e0", {63'd0, wr_valid}, 64'd0);
    chk("t1_req_e0", {63'd0, request}, 64'd0);
    @(negedge clk);
    chk("t1_wv_e1", {63'd0, wr_valid}, 64'd0);
    chk("t1_req_e1", {63'd0, request}, 64'd1);
    @(negedge clk);
    chk("t1_wv_e2", {63'd0, wr_valid}, 64'd0);
    @(negedge clk);
    chk("t1_wv_e3", {63'd0, wr_valid}, 64'd1);
    chk("t1_data", wr_data, 64'hA5);
    chk("t1_addr", {52'd0, wr_addr}, 64'd0);
    chk("t1_pri", {61'd0, wr_priority}, 64'd5);
    chk("t1_des", {60'd0, wr_des}, 64'd3);
    chk("t1_done", {63'd0, pkt_done}, 64'd1);
    chk("t1_len", {56'd0, pkt_len}, 64'd1);
    chk("t1_paddr", {52'd0, pkt_addr}, 64'd0);
    @(posedge clk);
    #1;
    drain();

    // Two back-to-back 4-beat packets.
    do_reset();
    send_pkt(4, 0);
    send_pkt(4, 0);
    drain();
    chk("t2_ndone", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("t2_a0", 64'(log_q[0].addr), 64'd0);
      chk("t2_l0", 64'(log_q[0].len), 64'd4);
      chk("t2_a1", 64'(log_q[1].addr), 64'd4);
      chk("t2_l1", 64'(log_q[1].len), 64'd4);
    end
    chk("t2_req_rises", 64'(req_rises), 64'd2);

    // Busy for 3 cycles mid-packet.
    do_reset();
    gconst = 0;
    send_pkt(8, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_req_wait", {63'd0, request}, 64'd1);
    gconst = 1;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!wr_valid && n < 100);
      chk("t3_first_wv", {63'd0, wr_valid}, 64'd1);
    end
    @(posedge clk);
    #1;
    bconst = 1;
    repeat (3) @(posedge clk);
    #1;
    bconst = 0;
    drain();
    chk("t3_words", 64'(wv_cnt), 64'd8);
    chk("t3_span", 64'(wv_last - wv_first + 1), 64'd11);

    // 20-beat packet through a 16-deep FIFO, with underruns.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send_beat(i == 0, i == 19, 3'd2, 4'd9, {32'd0, 32'(i)});
      if (i >= 16) begin
        repeat (3) @(posedge clk);
        #1;
      end
      if (i == 16) chk("t4_cut_through_req", {63'd0, request}, 64'd1);
    end
    drain();
    chk("t4_ndone", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      chk("t4_len", 64'(log_q[0].len), 64'd20);
      chk("t4_addr", 64'(log_q[0].addr), 64'd0);
    end

    // Address wrap: preload 4094 words then a 4-beat packet.
    do_reset();
    for (int p = 0; p < 292; p++) send_pkt(14, 0);
    send_pkt(6, 0);
    drain();
    log_q.delete();
    send_pkt(4, 0);
    drain();
    chk("t5_ndone", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      chk("t5_paddr", 64'(log_q[0].addr), 64'd4094);
      chk("t5_len", 64'(log_q[0].len), 64'd4);
    end
    chk("t5_last_addr", {52'd0, wr_addr}, 64'd1);

    // Random packets, random grant and busy.
    do_reset();
    gmode = 1;
    bmode = 1;
    npk = 40;
    for (int p = 0; p < npk; p++) send_pkt($urandom_range(1, 24), 2);
    drain();
    chk("t6_ndone", 64'(log_q.size()), 64'(npk));
    gmode = 0;
    bmode = 0;
    gconst = 1;

    // Reset while an oversized packet is being written.
    do_reset();
    for (int i = 0; i < 17; i++) send_beat(i == 0, 1'b0, 3'd1, 4'd1, 64'(i + 100));
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    send_pkt(1, 0);
    drain();
    chk("t7_ndone", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      chk("t7_addr", 64'(log_q[0].addr), 64'd0);
      chk("t7_len", 64'(log_q[0].len), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datasg_pkt.md
# datasg_pkt

Packet-aware write data segmenter for the SRAM controller. It accepts packet beats from one ingress port and buffers them in a parametrised FIFO. It then requests the SRAM write arbiter and, once granted, streams the buffered beats as SRAM write words with auto-incrementing, wrapping addresses. It honours `busy` back-pressure and reports each packet's start address and length for the descriptor/queue manager.

## Interface
Parameters:
- `DATA_W`, 64, SRAM word / beat width
- `ADDR_W`, 12, SRAM word address width
- `DES_W`, 4, destination port field width
- `PRI_W`, 3, priority field width
- `DEPTH`, 16, ingress FIFO depth in beats (power of two, ≥4)
- `LEN_W`, 8, packet length counter width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  ingress beat valid
- `in_ready`  out  1  ingress can accept (= FIFO not full)
- `in_data`  in  DATA_W  beat payload
- `in_sop`  in  1  first beat of packet
- `in_eop`  in  1  last beat of packet
- `in_priority`  in  PRI_W  packet priority (sampled with every beat, meaningful on sop)
- `in_des`  in  DES_W  destination port (as priority)
- `request`  out  1  write-arbiter request
- `grant`  in  1  arbiter grant, sampled in REQ
- `busy`  in  1  SRAM cannot accept a write this cycle
- `wr_valid`  out  1  write word valid
- `wr_addr`  out  ADDR_W  SRAM write address
- `wr_data`  out  DATA_W  SRAM write data
- `wr_priority`  out  PRI_W  priority of current packet
- `wr_des`  out  DES_W  destination of current packet
- `pkt_done`  out  1  one-cycle pulse, packet fully written
- `pkt_addr`  out  ADDR_W  start address of finished packet
- `pkt_len`  out  LEN_W  beats in finished packet

## Operation
- FIFO entry = {sop, eop, priority, des, data}. Push on `in_valid && in_ready`.
- `eop_cnt` counts complete packets held in the FIFO:
  - +1 on push of an eop beat, −1 on pop of an eop beat.
  - Both in the same cycle: unchanged.
- FSM states IDLE, REQ, XFER:
  - IDLE→REQ when `eop_cnt>0` or FIFO full. The FIFO-full case is a cut-through fallback for packets longer than `DEPTH`.
  - REQ→XFER when `grant`=1. Otherwise stay in REQ.
  - XFER: pop when `!busy && !empty`.
  - XFER→IDLE in the cycle an eop beat is popped.
- `request` = state∈{REQ, XFER}.
- Write pipeline: a popped beat appears on `wr_*` with `wr_valid`=1 at the next edge. With no pop, `wr_valid`=0 and the other `wr_*` outputs hold.
- Address counter `wptr`:
  - `wr_addr` = `wptr` of the written word.
  - `wptr` increments per written word and wraps 2^ADDR_W−1→0.
- On a sop beat written, `start_addr` is latched and the length counter is set to 1. Each further beat increments the length counter. The length wraps at 2^LEN_W; it is not saturated.
- `wr_priority`/`wr_des` take the sop beat's fields and hold them for the whole packet.
- `pkt_done`/`pkt_addr`/`pkt_len` assert in the same cycle as the eop word's `wr_valid`. A single-beat packet gives `pkt_len`=1.
- Empty FIFO in XFER (cut-through underrun): stay in XFER with `wr_valid`=0 and wait for beats.
- Malformed input is not checked; beats are written as received.
- Reset values: state IDLE; FIFO empty; `eop_cnt`, `wptr`, length counter = 0. All outputs 0 except `in_ready`=1.
- Reset mid-packet discards FIFO contents and the partial packet. No `pkt_done` is issued.

## Timing
- Complete packet in the FIFO at edge N: REQ from N+1 (`request`=1). With `grant` at N+1, XFER from N+2. First pop in cycle N+2, first `wr_valid` at N+3.
- Minimum push-to-write latency for a 1-beat packet: 4 cycles.
- Throughput: 1 word/cycle while `!busy` and the FIFO is non-empty.
- `busy`=1 in cycle k: no pop in k; `wr_valid`=0 in k+1.
- `request` drops one cycle after the eop pop. A new REQ may start the following cycle.
- `in_ready` is registered-full based. A push and a pop in the same cycle when not full are both allowed.

## Structure
- Package `datasg_pkg`: FSM state enum (IDLE/REQ/XFER) and default parameter constants.
- Sub-module `datasg_fifo`: synchronous FIFO, parametrised width/depth, with full/empty/count outputs.
- Top: FSM, `eop_cnt`, `wptr`, length counter, output registers.

## Test plan
- Single 1-beat packet (data 0xA5, pri 5, des 3), grant held high → `wr_valid` at cycle +4, `wr_addr`=0, `pkt_done` with `pkt_len`=1, `pkt_addr`=0.
- Two back-to-back 4-beat packets → addresses 0–3 then 4–7, two `pkt_done` pulses with len 4 and addr 0/4, second `request` after IDLE.
- `busy` high for 3 cycles mid-packet → `wr_valid` gaps of 3 cycles, no beat lost or duplicated, addresses contiguous.
- 20-beat packet with `DEPTH`=16 → request on FIFO full, underrun stalls without error, `pkt_len`=20.
- `wptr` preloaded by writing 4094 words, then a 4-beat packet → addresses 4094, 4095, 0, 1; `pkt_addr`=4094.
- `rst` asserted mid-packet → next cycle all outputs 0, `in_ready`=1, next packet written at addr 0, no `pkt_done` for the aborted packet.
